// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, end-of-program marker, PC step and
// the fetch sequencer state encoding.
package cpu_pkg;

  localparam int          XLEN          = 32;
  localparam logic [31:0] INSTR_NOP_END = 32'h0000_0000;
  localparam logic [31:0] PC_STEP       = 32'd4;

  typedef enum logic [0:0] {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fetch_state_e;

  // Instruction addresses are word aligned; the two low bits never reach the PC.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO holding {pc, instr} fetch entries with flush support.
// The caller guarantees no push into a full FIFO unless a pop happens too.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  // Storage array; stale contents are never observed because count gates the head.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      if (pop)  rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      case ({push, pop})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, streams ROM words into a fetch
// FIFO toward decode, follows execute redirects and stops on the all-zero word.
module if_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter int          QUEUE_DEPTH = 2,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic             halted,
  output logic [CNT_W-1:0] delivered_cnt
);

  localparam int            CW      = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

  fetch_state_e     state_r;
  logic [31:0]      pc_r;
  logic             halted_r;
  logic [CNT_W-1:0] cnt_r;
  logic             push_s;
  logic             pop_s;
  logic             valid_s;
  logic [CW-1:0]    fifo_count_s;
  logic [63:0]      head_s;

  fetch_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .W     (64)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .flush (redirect_valid),
    .din   ({pc_r, imem_rdata}),
    .count (fifo_count_s),
    .head  (head_s)
  );

  assign valid_s = (fifo_count_s != {CW{1'b0}});

  // Handshake decode; a redirect cancels both the pop and the push of its cycle.
  always_comb begin
    pop_s  = valid_s & out_ready & ~redirect_valid;
    push_s = 1'b0;
    if (state_r == FS_RUN) begin
      push_s = ~redirect_valid & (imem_rdata != INSTR_NOP_END) &
               ((fifo_count_s < DEPTH_C) | pop_s);
    end else begin
      push_s = 1'b0;
    end
  end

  // PC and run/halt state machine; redirect wins over everything but reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r     <= RESET_PC;
      state_r  <= FS_RUN;
      halted_r <= 1'b0;
    end else if (redirect_valid) begin
      pc_r     <= align_pc(redirect_pc);
      state_r  <= FS_RUN;
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        FS_RUN: begin
          if (push_s) begin
            pc_r <= pc_r + PC_STEP;
          end else begin
            pc_r <= pc_r;
          end
          if (imem_rdata == INSTR_NOP_END) begin
            state_r  <= FS_HALT;
            halted_r <= 1'b1;
          end else begin
            state_r  <= FS_RUN;
            halted_r <= 1'b0;
          end
        end
        FS_HALT: begin
          pc_r     <= pc_r;
          state_r  <= FS_HALT;
          halted_r <= 1'b1;
        end
        default: begin
          pc_r     <= pc_r;
          state_r  <= FS_HALT;
          halted_r <= 1'b1;
        end
      endcase
    end
  end

  // Count of instructions actually accepted by decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (pop_s) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign imem_addr     = pc_r;
  assign out_valid     = valid_s;
  assign out_pc        = valid_s ? head_s[63:32] : 32'd0;
  assign out_instr     = valid_s ? head_s[31:0]  : 32'd0;
  assign halted        = halted_r;
  assign delivered_cnt = cnt_r;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: ROM model, queue-based reference,
// a directed vector table, halt/redirect/reset sequences and random traffic.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        halted;
  logic [31:0] delivered_cnt;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [75];

  if_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .halted         (halted),
    .delivered_cnt  (delivered_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    logic [31:0] idx;
    idx = a >> 2;
    if (idx < 32'd75) return mem[idx];
    return 32'd0;
  endfunction

  assign imem_rdata = rom(imem_addr);

  // Reference model: program counter, halt flag, accepted count, queue of beats.
  logic [31:0] mpc;
  logic        mhalt;
  logic [31:0] mcnt;
  logic [63:0] mq[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic rv, input logic [31:0] rp, input logic rd);
    logic [31:0] w;
    logic [63:0] tmp;
    rst = r; redirect_valid = rv; redirect_pc = rp; out_ready = rd;
    w = rom(mpc);
    if (r) begin
      mq.delete(); mpc = 32'd0; mhalt = 1'b0; mcnt = 32'd0;
    end else if (rv) begin
      mq.delete(); mpc = rp & 32'hFFFF_FFFC; mhalt = 1'b0;
    end else begin
      if (rd && mq.size() > 0) begin
        tmp = mq.pop_front();
        mcnt = mcnt + 32'd1;
      end
      if (!mhalt) begin
        if (w == 32'd0) mhalt = 1'b1;
        else if (mq.size() < 2) begin
          mq.push_back({mpc, w});
          mpc = mpc + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("m_valid", {63'd0, out_valid}, {63'd0, mq.size() != 0});
    chk("m_head", {out_pc, out_instr}, (mq.size() != 0) ? mq[0] : 64'd0);
    chk("m_addr", {32'd0, imem_addr}, {32'd0, mpc});
    chk("m_halted", {63'd0, halted}, {63'd0, mhalt});
    chk("m_cnt", {32'd0, delivered_cnt}, {32'd0, mcnt});
  endtask

  typedef struct {
    logic        r;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic [31:0] eaddr;
    logic [31:0] ecnt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [31:0] last_pc;
    logic [31:0] last_instr;
    int          guard;

    for (int i = 0; i < 75; i++) mem[i] = 32'h1000_0013 + (i << 7);
    mem[0]  = 32'h00100f93;
    mem[1]  = 32'h01f02023;
    mem[2]  = 32'h01f02423;
    mem[12] = 32'h0ec5da63;
    mem[63] = 32'hf35ff0ef;
    mem[73] = 32'h00008067;
    mem[74] = 32'h0000_0000;
    mpc = 32'd0; mhalt = 1'b0; mcnt = 32'd0;

    // Reset, stall five cycles, drain, then redirect to 252 while full.
    tbl[0]  = '{1'b1, 1'b0, 32'd0,   1'b0, 1'b0, 32'd0,   32'd0,        32'd0,   32'd0};
    tbl[1]  = '{1'b0, 1'b0, 32'd0,   1'b0, 1'b1, 32'd0,   32'h00100f93, 32'd4,   32'd0};
    tbl[2]  = '{1'b0, 1'b0, 32'd0,   1'b0, 1'b1, 32'd0,   32'h00100f93, 32'd8,   32'd0};
    tbl[3]  = '{1'b0, 1'b0, 32'd0,   1'b0, 1'b1, 32'd0,   32'h00100f93, 32'd8,   32'd0};
    tbl[4]  = '{1'b0, 1'b0, 32'd0,   1'b0, 1'b1, 32'd0,   32'h00100f93, 32'd8,   32'd0};
    tbl[5]  = '{1'b0, 1'b0, 32'd0,   1'b0, 1'b1, 32'd0,   32'h00100f93, 32'd8,   32'd0};
    tbl[6]  = '{1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd4,   32'h01f02023, 32'd12,  32'd1};
    tbl[7]  = '{1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd8,   32'h01f02423, 32'd16,  32'd2};
    tbl[8]  = '{1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd12,  mem[3],       32'd20,  32'd3};
    tbl[9]  = '{1'b0, 1'b0, 32'd0,   1'b0, 1'b1, 32'd12,  mem[3],       32'd20,  32'd3};
    tbl[10] = '{1'b0, 1'b1, 32'd255, 1'b1, 1'b0, 32'd0,   32'd0,        32'd252, 32'd3};
    tbl[11] = '{1'b0, 1'b0, 32'd0,   1'b0, 1'b1, 32'd252, 32'hf35ff0ef, 32'd256, 32'd3};

    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].r, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      chk($sformatf("t%0d_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].ev});
      chk($sformatf("t%0d_pc", i), {32'd0, out_pc}, {32'd0, tbl[i].epc});
      chk($sformatf("t%0d_instr", i), {32'd0, out_instr}, {32'd0, tbl[i].einstr});
      chk($sformatf("t%0d_addr", i), {32'd0, imem_addr}, {32'd0, tbl[i].eaddr});
      chk($sformatf("t%0d_cnt", i), {32'd0, delivered_cnt}, {32'd0, tbl[i].ecnt});
    end

    // Full run to the end-of-program word.
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    last_pc = 32'hFFFF_FFFF; last_instr = 32'd0;
    guard = 0;
    while (!(halted && !out_valid) && guard < 200) begin
      if (out_valid) begin
        last_pc = out_pc; last_instr = out_instr;
      end
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      guard++;
    end
    chk("run_timeout", {63'd0, guard < 200}, 64'd1);
    chk("last_pc", {32'd0, last_pc}, 64'd292);
    chk("last_instr", {32'd0, last_instr}, 64'h0000_8067);
    chk("halt_addr", {32'd0, imem_addr}, 64'd296);
    chk("halt_flag", {63'd0, halted}, 64'd1);
    chk("halt_cnt", {32'd0, delivered_cnt}, 64'd74);
    chk("halt_valid", {63'd0, out_valid}, 64'd0);

    // Redirect out of HALT.
    cycle(1'b0, 1'b1, 32'd48, 1'b1);
    chk("redir_halted", {63'd0, halted}, 64'd0);
    chk("redir_valid", {63'd0, out_valid}, 64'd0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    chk("redir_head", {out_pc, out_instr}, {32'd48, 32'h0ec5da63});

    // Mid-stream reset near PC 100.
    guard = 0;
    while (imem_addr < 32'd100 && guard < 100) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      guard++;
    end
    chk("mid_timeout", {63'd0, guard < 100}, 64'd1);
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_cnt", {32'd0, delivered_cnt}, 64'd0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    chk("rst_head", {out_pc, out_instr}, {32'd0, 32'h00100f93});

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 80) << 2) | $urandom_range(0, 3),
            $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
